// File: rtl/fifo_check_pkg.sv
// Shared types for the duplicate-filtering FIFO writer: FSM state encoding and default counter width.
// No logic here; latency and backpressure are properties of fifo_check_writer.
// Imported by the top and by the statistics counters.
package fifo_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam int CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
// Latency: count visible the cycle after inc.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
  parameter int WIDTH = fifo_check_pkg::CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_check_writer.sv
// Writes each accepted word into the checking FIFO unless the FIFO already holds it.
// Latency: accept->wren 1 cycle when FIFO empty, else 3 cycles + check response + full stalls.
// Backpressure: in_ready low whenever a word is held; fifo_full stalls the write in WRITE.
module fifo_check_writer
  import fifo_check_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int CHECK_TIMEOUT = 64,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic                  wren,
  output logic [DATA_WIDTH-1:0] wdat,
  output logic                  check_req,
  output logic [DATA_WIDTH-1:0] check_dat,
  input  logic                  check_res,
  input  logic                  check_vld,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic [CNT_WIDTH-1:0]  dup_cnt,
  output logic [CNT_WIDTH-1:0]  tmo_cnt
);

  localparam int            TW       = $clog2(CHECK_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(CHECK_TIMEOUT - 1);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [TW-1:0]         timer;
  logic                  accept;
  logic                  rsp_dup;
  logic                  rsp_new;
  logic                  tmo_hit;
  logic                  wr_fire;

  // Outputs are gated with rst so they read zero even before the synchronous reset lands.
  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign rsp_dup   = (state == WAIT) && check_vld && check_res;
  assign rsp_new   = (state == WAIT) && check_vld && !check_res;
  assign tmo_hit   = (state == WAIT) && !check_vld && (timer == TMO_LAST);
  assign wr_fire   = (state == WRITE) && !fifo_full && !rst;
  assign wren      = wr_fire;
  assign wdat      = wr_fire ? hold_reg : '0;
  assign check_req = (state == REQ) && !rst;
  assign check_dat = (((state == REQ) || (state == WAIT)) && !rst) ? hold_reg : '0;
  assign busy      = (state != IDLE) && !rst;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fifo_empty ? WRITE : REQ;
      REQ:     state_nxt = WAIT;
      // A response on the last timer cycle wins over the timeout.
      WAIT: begin
        if (rsp_dup) begin
          state_nxt = IDLE;
        end else if (rsp_new || tmo_hit) begin
          state_nxt = WRITE;
        end
      end
      WRITE:   if (wr_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_reg <= '0;
      timer    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        hold_reg <= in_data;
      end
      if (state == REQ) begin
        timer <= '0;
      end else if (state == WAIT) begin
        timer <= timer + TW'(1);
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wr_fire),
    .cnt (wr_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_dup_cnt (
    .clk (clk),
    .rst (rst),
    .inc (rsp_dup),
    .cnt (dup_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_tmo_cnt (
    .clk (clk),
    .rst (rst),
    .inc (tmo_hit),
    .cnt (tmo_cnt)
  );

endmodule

// File: doc/fifo_check_writer.md
FIFO_CHECK_WRITER -- requirements
Module: fifo_check_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of data words and of the FIFO write and check data.
REQ-002 Parameter CHECK_TIMEOUT, default 64, the number of WAIT cycles allowed before a check is declared not-found.
REQ-003 Parameter CNT_WIDTH, default 16, the width of each statistics counter.
REQ-004 clk  input  1  clock; all logic is on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream word is available.
REQ-007 in_data  input  DATA_WIDTH  upstream word.
REQ-008 in_ready  output  1  the block accepts in_data this cycle.
REQ-009 fifo_full / fifo_empty  input  1 each  full and empty status from the checking FIFO.
REQ-010 wren  output  1  one-cycle write strobe to the FIFO.
REQ-011 wdat  output  DATA_WIDTH  FIFO write data.
REQ-012 check_req  output  1  one-cycle content-check request to the FIFO.
REQ-013 check_dat  output  DATA_WIDTH  the word being searched for; it is held stable for the whole check.
REQ-014 check_res / check_vld  input  1 each  FIFO check result (1 = match found) and its valid strobe.
REQ-015 busy  output  1  the state is not IDLE.
REQ-016 wr_cnt / dup_cnt / tmo_cnt  output  CNT_WIDTH each  the number of words written, dropped as duplicates, and timed out.

Function
REQ-017 The block SHALL write each accepted word to the FIFO only if the word is not already present in the FIFO.
REQ-018 The FSM SHALL have four states:
- IDLE: in_ready=1; when in_valid=1, capture in_data into hold_reg; if fifo_empty=1 go to WRITE, else go to REQ.
- REQ: check_req=1 for exactly one cycle with check_dat=hold_reg; go to WAIT; clear timer.
- WAIT: check_vld=1 with check_res=1 increments dup_cnt and returns to IDLE; check_vld=1 with check_res=0 goes to WRITE; timer reaching CHECK_TIMEOUT-1 with no check_vld increments tmo_cnt and goes to WRITE.
- WRITE: if fifo_full=0, assert wren=1 with wdat=hold_reg, increment wr_cnt and return to IDLE; otherwise remain in WRITE with wren=0.
REQ-019 in_ready SHALL be combinational and equal to (state==IDLE) & ~rst; exactly one word is accepted per in_valid&in_ready cycle.
REQ-020 check_dat SHALL equal hold_reg in the REQ and WAIT states and SHALL be 0 in all other states.
REQ-021 wdat SHALL be 0 whenever wren=0.
REQ-022 check_vld SHALL be ignored in the IDLE, REQ and WRITE states.
REQ-023 In WAIT, the first check_vld received SHALL decide the outcome.
REQ-024 If check_vld and the timeout occur in the same cycle, check_vld SHALL take priority.
REQ-025 Latency SHALL be:
- fifo_empty path: accept to wren is 1 cycle.
- check path: accept to wren is 3 cycles + the FIFO response time + fifo_full stall cycles.
REQ-026 The timer SHALL be $clog2(CHECK_TIMEOUT)+1 bits wide and SHALL run only in WAIT.
REQ-027 The counters SHALL saturate at all-ones and never wrap.
REQ-028 wren and check_req SHALL never be asserted in the same cycle.
REQ-029 The block SHALL have at most one request outstanding at a time.

Reset
REQ-030 While rst=1:
- state = IDLE;
- hold_reg, timer, wr_cnt, dup_cnt, tmo_cnt = 0;
- wren, wdat, check_req, check_dat, busy, in_ready = 0.
REQ-031 A reset asserted in REQ, WAIT or WRITE SHALL discard the held word with no wren and no counter update; a late check_vld arriving after reset SHALL be ignored.

Structure
REQ-032 A shared package fifo_check_pkg SHALL hold the state enum (IDLE, REQ, WAIT, WRITE) and the default CNT_WIDTH.
REQ-033 A single sub-module, sat_counter (parameter WIDTH; inputs clk, rst, inc; output cnt), SHALL be instantiated three times for the statistics counters.
REQ-034 Everything else SHALL be flat.

Verification
REQ-035 fifo_empty=1, send 0xA5A5A5A5 -> wren=1 with wdat=0xA5A5A5A5 on the cycle after acceptance; wr_cnt=1; check_req never asserted.
REQ-036 fifo_empty=0, send 0x12345678, model answers check_vld=1 with check_res=1 three cycles later -> no wren; dup_cnt=1; in_ready=1 on the next cycle.
REQ-037 Same as REQ-036 but check_res=0 and fifo_full=1 for 5 cycles -> wren held off for 5 cycles, then a single wren with 0x12345678; wr_cnt=1.
REQ-038 CHECK_TIMEOUT=8, model never answers -> exactly 8 WAIT cycles, then wren; tmo_cnt=1.
REQ-039 rst pulsed in WAIT, then check_vld=1 arrives -> no wren; all counters 0; state IDLE.
REQ-040 CNT_WIDTH=4, 20 writes on the empty path -> wr_cnt saturates at 15.
